// File: rtl/demux4_pkg.sv
// Shared constants and lane state type for the registered 1-to-4 demultiplexer.
// Optional per-lane statistics are enabled with DEMUX4_STATS_EN.
package demux4_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } lane_state_t;

endpackage

// File: rtl/demux4_lane.sv
// One output lane: one-entry buffer with an EMPTY/FULL FSM and, with DEMUX4_STATS_EN,
// a wrapping accept counter. The top only asserts load_i when the lane can take a word.
module demux4_lane
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX4_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output lane_state_t      state_o
`ifdef DEMUX4_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_o
`endif
);

  lane_state_t      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // A load always wins over a drain: a same-cycle drain+load keeps the lane FULL.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    if (load_i) begin
      data_d = data_i;
    end
    case (state_q)
      EMPTY: if (load_i) state_d = FULL;
      FULL:  if (!load_i && ready_i) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign data_o  = data_q;
  assign state_o = state_q;

`ifdef DEMUX4_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer: routes one word per handshake to the lane picked by in_sel.
// Define DEMUX4_STATS_EN to add per-lane accept counters on out_cnt.
//
// Handshakes: a word moves when valid and ready are both high at a rising edge. in_ready is
// combinational from the selected lane's state and out_ready, never from in_valid; a producer
// held off must keep in_data/in_sel stable until accepted.
module demux4_reg
  import demux4_pkg::*;
#(
  parameter int WIDTH = 32
`ifdef DEMUX4_STATS_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [LANES-1:0]       out_valid,
  input  logic [LANES-1:0]       out_ready,
  output logic [LANES*WIDTH-1:0] out_data
`ifdef DEMUX4_STATS_EN
  ,
  output logic [LANES*CNT_W-1:0] out_cnt
`endif
);

  lane_state_t      lane_state [LANES];
  logic [LANES-1:0] lane_load;
  logic             accept;

  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_load[i] = accept && (in_sel == SEL_W'(i));
    assign out_valid[i] = (lane_state[i] == FULL);

    demux4_lane #(
      .WIDTH (WIDTH)
`ifdef DEMUX4_STATS_EN
      ,
      .CNT_W (CNT_W)
`endif
    ) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load_i  (lane_load[i]),
      .data_i  (in_data),
      .ready_i (out_ready[i]),
      .data_o  (out_data[i*WIDTH +: WIDTH]),
      .state_o (lane_state[i])
`ifdef DEMUX4_STATS_EN
      ,
      .cnt_o   (out_cnt[i*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
